// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM encoding, word width, reset PC, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Buffered instruction tagged with its fetch address (pc in the upper half).
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x fetch_entry_t synchronous FIFO with sync clear.
// Latency: a push is visible at head the following cycle.
// Backpressure: none internally; the caller must never push while full (pop on empty is ignored).
// Ports: clk/reset, clear (flush all), push/push_dat, pop, head, count, empty, full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_dat,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order imem requests, buffers tagged responses, feeds decode.
// Latency: response at cycle t is on id_* at t+1 when the buffer is empty; 1 instr/cycle.
// Backpressure: id_ready low holds id_*; issue stops once in-flight + buffered reaches FIFO_DEPTH.
// Ports: clk/reset; imem_req_valid/ready + imem_addr; imem_rsp_valid/data;
//        redirect_valid/pc; id_valid/ready + id_instr/id_pc.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_q, out_d;

  logic              redirect_act;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [SW-1:0]     inflight_total;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_dat;

  // BOOT ignores redirects: nothing has been fetched yet.
  assign redirect_act = redirect_valid && (state_q != BOOT);

  // Conservative cap: a same-cycle pop does not free a slot until next cycle.
  assign inflight_total = SW'(out_q) + SW'(fifo_count);
  assign imem_req_valid = (state_q == RUN) && !redirect_valid &&
                          (inflight_total < SW'(FIFO_DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses in a redirect cycle belong to the squashed stream.
  assign push     = (state_q == RUN) && imem_rsp_valid && !redirect_act;
  assign pop      = !fifo_empty && id_ready && !redirect_act;
  assign push_dat = '{pc: rsp_pc_q, instr: imem_rsp_data};

  // Saturate at zero so a stray response after reset cannot wrap the counter.
  always_comb begin
    out_d = out_q;
    if (req_fire && !imem_rsp_valid) begin
      out_d = out_q + CW'(1);
    end else if (!req_fire && imem_rsp_valid && (out_q != '0)) begin
      out_d = out_q - CW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (req_fire) begin
      pc_d = pc_q + WORD_W'(1);
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + WORD_W'(1);
    end
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (out_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect_act) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      state_d  = (out_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect_act),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign id_valid = !fifo_empty;
  assign id_instr = fifo_empty ? '0 : fifo_head.instr;
  assign id_pc    = fifo_empty ? '0 : fifo_head.pc;

  // The issue cap must make overflow impossible.
  push_never_full : assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule
